// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receiver state encoding and bit-timing helper
package uart_pkg;
  localparam int CLKS_PER_BIT_DEFAULT = 5208;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;
  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received byte and status strobes out
interface uart_rx_if;
  logic       in_rx;
  logic [7:0] data_received;
  logic       done;
  logic       frame_error;
  logic       busy;
  modport master (output in_rx, input data_received, done, frame_error, busy);
  modport slave  (input in_rx, output data_received, done, frame_error, busy);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer that resets to 1 (idle-high pins)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver sampling each bit once at its centre
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input logic      clk,
  input logic      rst_n,
  uart_rx_if.slave rx_if
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(half_bit(CLKS_PER_BIT) - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  logic          rx_s;
  rx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          done_q;
  logic          ferr_q;
  logic          busy_q;
  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_if.in_rx),
    .q     (rx_s)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (!rx_s) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            state_q <= rx_s ? IDLE : DATA;
            busy_q  <= !rx_s;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s;
            idx_q          <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= rx_s ? IDLE : BREAK;
            busy_q  <= !rx_s;
            done_q  <= rx_s;
            ferr_q  <= !rx_s;
            if (rx_s) data_q <= shift_q;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        // a held-low line stays here so it is not decoded as repeated frames
        BREAK: begin
          if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  assign rx_if.data_received = data_q;
  assign rx_if.done          = done_q;
  assign rx_if.frame_error   = ferr_q;
  assign rx_if.busy          = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames with a behavioural transmitter and checks decoded events
module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int TCK  = 10;
  localparam int BIT  = CPB * TCK;
  localparam int FERR = 256;
  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         per;
    bit         gap;
    int         exp_ev;
  } vec_t;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cyc = -1;
  int   viol = 0;
  int   last_good = 0;
  int   exp_q[$];
  int   got_q[$];
  vec_t tbl[7];
  uart_rx_if rif ();
  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (rif)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rif.done) begin
        got_q.push_back(int'(rif.data_received));
        done_cyc = cyc;
      end
      if (rif.frame_error) got_q.push_back(FERR);
      if (rif.done && rif.frame_error) viol++;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] b, input bit stop, input int per);
    rif.in_rx = 1'b0;
    #(per);
    for (int i = 0; i < 8; i++) begin
      rif.in_rx = b[i];
      #(per);
    end
    rif.in_rx = stop;
    #(per);
    rif.in_rx = 1'b1;
  endtask
  task automatic expect_frame(input logic [7:0] b, input bit stop);
    exp_q.push_back(stop ? int'(b) : FERR);
    if (stop) last_good = int'(b);
  endtask
  task automatic check_events(input string tag);
    int e;
    int g;
    chk({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : -1;
      chk({tag, " event"}, 32'(g), 32'(e));
    end
    got_q.delete();
  endtask
  task automatic wait_not_busy(input string tag);
    for (int i = 0; i < 10 && rif.busy; i++) @(negedge clk);
    chk(tag, 32'(rif.busy), 0);
  endtask
  initial begin
    int start_cyc;
    int end_cyc;
    int per;
    int gap;
    logic [7:0] b;
    bit stop;
    int pers[3] = '{155, 160, 165};
    tbl = '{
      '{8'h00, 1'b1, 160, 1'b0, 8'h00},
      '{8'hFF, 1'b1, 160, 1'b0, 8'hFF},
      '{8'h01, 1'b1, 160, 1'b0, 8'h01},
      '{8'h80, 1'b1, 160, 1'b1, 8'h80},
      '{8'h96, 1'b1, 155, 1'b1, 8'h96},
      '{8'h96, 1'b1, 165, 1'b1, 8'h96},
      '{8'h3C, 1'b0, 160, 1'b1, FERR}
    };
    rst_n = 1'b0;
    rif.in_rx = 1'b1;
    #12;
    chk("rst data", 32'(rif.data_received), 0);
    chk("rst done", 32'(rif.done), 0);
    chk("rst ferr", 32'(rif.frame_error), 0);
    chk("rst busy", 32'(rif.busy), 0);
    #20;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle busy", 32'(rif.busy), 0);
    // loopback-style frame with exact latency and busy-rise timing
    start_cyc = cyc;
    done_cyc = -1;
    fork
      send_frame(8'hA5, 1'b1, BIT);
      begin
        repeat (3) @(negedge clk);
        chk("busy before T0", 32'(rif.busy), 0);
        @(negedge clk);
        chk("busy after T0", 32'(rif.busy), 1);
      end
    join
    end_cyc = cyc;
    expect_frame(8'hA5, 1'b1);
    #(2 * BIT);
    check_events("loopback");
    chk("loopback latency", 32'(done_cyc - start_cyc), 32'(3 + HALF + 9 * CPB));
    chk("done before tx end", 32'(done_cyc < end_cyc), 1);
    chk("loopback data", 32'(rif.data_received), 32'(last_good));
    chk("loopback busy", 32'(rif.busy), 0);
    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].per);
      exp_q.push_back(tbl[i].exp_ev);
      if (tbl[i].exp_ev != FERR) last_good = tbl[i].exp_ev;
      if (tbl[i].gap) begin
        #(3 * BIT);
        check_events($sformatf("vec%0d", i));
        chk($sformatf("vec%0d data", i), 32'(rif.data_received), 32'(last_good));
      end
    end
    // glitch shorter than half a bit
    @(posedge clk);
    #1;
    rif.in_rx = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch busy", 32'(rif.busy), 1);
    #(6 * TCK - 45);
    rif.in_rx = 1'b1;
    wait_not_busy("glitch busy fall");
    #(2 * BIT);
    check_events("glitch");
    // stop bit low followed by a held-low line
    @(posedge clk);
    #1;
    send_frame(8'h3C, 1'b0, BIT);
    rif.in_rx = 1'b0;
    expect_frame(8'h3C, 1'b0);
    #(40 * TCK);
    chk("break busy", 32'(rif.busy), 1);
    rif.in_rx = 1'b1;
    wait_not_busy("break busy fall");
    check_events("ferr");
    chk("ferr data kept", 32'(rif.data_received), 32'(last_good));
    send_frame(8'h55, 1'b1, BIT);
    expect_frame(8'h55, 1'b1);
    #(2 * BIT);
    check_events("after ferr");
    chk("after ferr data", 32'(rif.data_received), 32'h55);
    // reset asserted during data bit 4, released once the line is back high
    @(posedge clk);
    #1;
    fork
      send_frame(8'hC3, 1'b1, BIT);
      begin
        #(5 * BIT + 40);
        chk("pre-reset busy", 32'(rif.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst data", 32'(rif.data_received), 0);
        chk("midrst busy", 32'(rif.busy), 0);
        chk("midrst done", 32'(rif.done), 0);
        chk("midrst ferr", 32'(rif.frame_error), 0);
        #(4 * BIT + 20);
        rst_n = 1'b1;
      end
    join
    last_good = 0;
    #(2 * BIT);
    check_events("midrst");
    send_frame(8'h5A, 1'b1, BIT);
    expect_frame(8'h5A, 1'b1);
    #(2 * BIT);
    check_events("post reset");
    chk("post reset data", 32'(rif.data_received), 32'h5A);
    // random frames, rates and gaps against the frame model
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      per = pers[$urandom_range(0, 2)];
      send_frame(b, stop, per);
      expect_frame(b, stop);
      gap = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      #(gap * per);
    end
    #(4 * BIT);
    check_events("random");
    chk("random data", 32'(rif.data_received), 32'(last_good));
    chk("done/ferr exclusive", 32'(viol), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
